hilo_mdu: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage that writes the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO, and optionally MADD/MADDU. It drives the HI/LO write port of the register file and the EX-stage HI/LO forwarding inputs. It also raises a pipeline stall request while an operation is in flight.

---
 rtl/hilo_mdu.sv | 188 ++++++++++++++++++
 tb/tb_hilo_mdu.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mdu.sv
`default_nettype none
// ============================================================================
// hilo_mdu : multi-cycle MULT/DIV/MTHI/MTLO unit writing the HI/LO pair.
//            MADD/MADDU accumulate is built only when `MDU_MADD_EN is defined.
// Rev 1.0
// ============================================================================
module hilo_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic [31:0] hi_rdata,
  input  logic [31:0] lo_rdata,
  output logic        busy,
  output logic        stall_req,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MADDU = 3'd7;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] a_q, b_q, rem_q, quo_q, dvs_q, hi_q, lo_q;
  logic        sgn_q, wr_hi_q, wr_lo_q;

  logic        is_mul_d, is_div_d, is_mt_d, op_sgn_d, go_d;
  logic [31:0] a_mag_d, b_mag_d;
  logic [63:0] prod_d;
  logic [32:0] shift_d, trial_d;
  logic [31:0] rem_d, quo_d, hi_fix_d, lo_fix_d;

`ifdef MDU_MADD_EN
  logic        madd_q;
  logic [63:0] acc_q;
  assign is_mul_d = (op == OP_MULT) || (op == OP_MULTU) ||
                    (op == OP_MADD) || (op == OP_MADDU);
`else
  logic unused_rdata;
  assign unused_rdata = ^{hi_rdata, lo_rdata};
  assign is_mul_d = (op == OP_MULT) || (op == OP_MULTU);
`endif

  assign is_div_d = (op == OP_DIV) || (op == OP_DIVU);
  assign is_mt_d  = (op == OP_MTHI) || (op == OP_MTLO);
  assign op_sgn_d = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
  assign go_d     = start && !flush && (state_q == S_IDLE);
  assign a_mag_d  = (op_sgn_d && a[31]) ? -a : a;
  assign b_mag_d  = (op_sgn_d && b[31]) ? -b : b;

  // Sign-extending to 64 bits makes one multiplier serve both signed and unsigned.
  always_comb begin
    prod_d = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
`ifdef MDU_MADD_EN
    if (madd_q) prod_d = prod_d + acc_q;
`endif
  end

  // Restoring step: dividend bits shift out of quo_q into the partial remainder.
  assign shift_d = {rem_q, quo_q[31]};
  assign trial_d = shift_d - {1'b0, dvs_q};
  assign rem_d   = trial_d[32] ? shift_d[31:0] : trial_d[31:0];
  assign quo_d   = {quo_q[30:0], ~trial_d[32]};

  always_comb begin
    hi_fix_d = (sgn_q && a_q[31]) ? -rem_q : rem_q;
    lo_fix_d = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
    if (b_q == 32'h0) begin
      lo_fix_d = 32'hFFFF_FFFF;
      hi_fix_d = a_q;
    end else if (sgn_q && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF)) begin
      lo_fix_d = 32'h8000_0000;
      hi_fix_d = 32'h0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign stall_req = !rst && ((state_q == S_MUL) || (state_q == S_DIV) ||
                              (go_d && (is_mul_d || is_div_d)));
  assign hi_we     = (state_q == S_DONE) && wr_hi_q && !flush;
  assign lo_we     = (state_q == S_DONE) && wr_lo_q && !flush;
  assign hi_wdata  = hi_q;
  assign lo_wdata  = lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      rem_q   <= 32'h0;
      quo_q   <= 32'h0;
      dvs_q   <= 32'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      sgn_q   <= 1'b0;
      wr_hi_q <= 1'b0;
      wr_lo_q <= 1'b0;
`ifdef MDU_MADD_EN
      madd_q  <= 1'b0;
      acc_q   <= 64'h0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_d) begin
            a_q     <= a;
            b_q     <= b;
            sgn_q   <= op_sgn_d;
            wr_hi_q <= 1'b0;
            wr_lo_q <= 1'b0;
            if (is_mul_d) begin
              state_q <= S_MUL;
`ifdef MDU_MADD_EN
              madd_q  <= (op == OP_MADD) || (op == OP_MADDU);
              acc_q   <= {hi_rdata, lo_rdata};
`endif
            end else if (is_div_d) begin
              state_q <= S_DIV;
              cnt_q   <= 6'd32;
              rem_q   <= 32'h0;
              quo_q   <= a_mag_d;
              dvs_q   <= b_mag_d;
            end else if (is_mt_d) begin
              state_q <= S_DONE;
              wr_hi_q <= (op == OP_MTHI);
              wr_lo_q <= (op == OP_MTLO);
              if (op == OP_MTHI) hi_q <= a;
              else               lo_q <= a;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            {hi_q, lo_q} <= prod_d;
            wr_hi_q      <= 1'b1;
            wr_lo_q      <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (cnt_q != 6'd0) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 6'd1;
          end else begin
            hi_q    <= hi_fix_d;
            lo_q    <= lo_fix_d;
            wr_hi_q <= 1'b1;
            wr_lo_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          wr_hi_q <= 1'b0;
          wr_lo_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_mdu.sv
`default_nettype none
// tb_hilo_mdu : self-checking bench for hilo_mdu against an arithmetic reference model.
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b, hi_rdata, lo_rdata;
  logic        busy, stall_req, hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  // observed results of one operation
  int          r_lat, r_stcnt;
  logic        r_hw, r_lw, r_st0, r_post_we, r_post_busy;
  logic [31:0] r_hd, r_ld;
  // expected results from the model
  int          e_lat;
  logic        e_hw, e_lw;
  logic [31:0] e_hd, e_ld;

  hilo_mdu dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .hi_rdata (hi_rdata),
    .lo_rdata (lo_rdata),
    .busy     (busy),
    .stall_req(stall_req),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog timeout");
  end

  // Reference: strobe latency, strobe set and HI/LO values from plain arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] av, bv, hr, lr);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, uq, ur, p;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    ua = {32'd0, av};
    ub = {32'd0, bv};
    e_lat = 0; e_hw = 1'b0; e_lw = 1'b0; e_hd = 32'h0; e_ld = 32'h0;
    case (o)
      3'd0, 3'd1, 3'd6, 3'd7: begin
        if (o < 3'd6 || MADD_EN) begin
          if (o == 3'd0 || o == 3'd6) p = sa * sb;
          else                        p = ua * ub;
          if (o >= 3'd6) p = p + {hr, lr};
          e_lat = 2; e_hw = 1'b1; e_lw = 1'b1;
          e_hd = p[63:32]; e_ld = p[31:0];
        end
      end
      3'd2, 3'd3: begin
        e_lat = 34; e_hw = 1'b1; e_lw = 1'b1;
        if (bv == 32'h0) begin
          e_ld = 32'hFFFF_FFFF; e_hd = av;
        end else if (o == 3'd2 && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) begin
          e_ld = 32'h8000_0000; e_hd = 32'h0;
        end else if (o == 3'd2) begin
          sq = sa / sb; sr = sa % sb;
          e_ld = sq[31:0]; e_hd = sr[31:0];
        end else begin
          uq = ua / ub; ur = ua % ub;
          e_ld = uq[31:0]; e_hd = ur[31:0];
        end
      end
      3'd4: begin e_lat = 1; e_hw = 1'b1; e_hd = av; end
      default: begin e_lat = 1; e_lw = 1'b1; e_ld = av; end
    endcase
  endfunction

  // Called just after a falling edge; issues one op and records what the DUT does.
  // poke_k: cycle offset at which a stray MTHI start is driven mid-operation.
  task automatic run_op(input logic [2:0] o, input logic [31:0] av, bv, hr, lr,
                        input int poke_k);
    start = 1'b1; op = o; a = av; b = bv; hi_rdata = hr; lo_rdata = lr;
    #1 r_st0 = stall_req;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; hi_rdata = $urandom; lo_rdata = $urandom;
    r_lat = 0; r_stcnt = 0; r_hw = 1'b0; r_lw = 1'b0; r_hd = 32'h0; r_ld = 32'h0;
    for (int k = 1; k <= 40 && r_lat == 0; k++) begin
      @(negedge clk);
      if (stall_req) r_stcnt++;
      if (hi_we || lo_we) begin
        r_lat = k; r_hw = hi_we; r_lw = lo_we; r_hd = hi_wdata; r_ld = lo_wdata;
      end
      start = (k == poke_k);
      if (start) begin op = 3'd4; a = 32'hA5A5_A5A5; end
    end
    start = 1'b0;
    @(negedge clk);
    r_post_we = hi_we || lo_we;
    r_post_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5; flush = 1'b0;
    hi_rdata = 32'h0; lo_rdata = 32'h0;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({busy, stall_req, hi_we, lo_we, hi_wdata, lo_wdata} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b stall=%b we=%b%b hi=%h lo=%h, required all 0",
               busy, stall_req, hi_we, lo_we, hi_wdata, lo_wdata);
    end
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_mult();
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 0);
    n_assert++;
    if (r_lat !== 2 || r_hd !== 32'hFFFF_FFFF || r_ld !== 32'hFFFF_FFFA || !(r_hw && r_lw)) begin
      n_fail++;
      $display("FAIL mult: got lat=%0d hi=%h lo=%h we=%b%b, required lat=2 hi=ffffffff lo=fffffffa we=11",
               r_lat, r_hd, r_ld, r_hw, r_lw);
    end
    n_assert++;
    if (r_st0 !== 1'b1 || r_stcnt !== 1) begin
      n_fail++;
      $display("FAIL mult_stall: got st0=%b cycles=%0d, required 1 and 1", r_st0, r_stcnt);
    end
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0, 0);
    n_assert++;
    if (r_lat !== 2 || r_hd !== 32'h0000_0002 || r_ld !== 32'hFFFF_FFFA) begin
      n_fail++;
      $display("FAIL multu: got lat=%0d hi=%h lo=%h, required lat=2 hi=00000002 lo=fffffffa",
               r_lat, r_hd, r_ld);
    end
  endtask

  task automatic test_div();
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0, 5);
    n_assert++;
    if (r_lat !== 34 || r_ld !== 32'hFFFF_FFFD || r_hd !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL div_neg7_by_2: got lat=%0d hi=%h lo=%h, required lat=34 hi=ffffffff lo=fffffffd",
               r_lat, r_hd, r_ld);
    end
    n_assert++;
    if (r_st0 !== 1'b1 || r_stcnt !== 33) begin
      n_fail++;
      $display("FAIL div_stall: got st0=%b cycles=%0d, required 1 and 33", r_st0, r_stcnt);
    end
    run_op(3'd3, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 0);
    n_assert++;
    if (r_lat !== 34 || r_ld !== 32'hFFFF_FFFF || r_hd !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL divu_by_zero: got lat=%0d hi=%h lo=%h, required lat=34 hi=00001234 lo=ffffffff",
               r_lat, r_hd, r_ld);
    end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);
    n_assert++;
    if (r_lat !== 34 || r_ld !== 32'h8000_0000 || r_hd !== 32'h0) begin
      n_fail++;
      $display("FAIL div_overflow: got lat=%0d hi=%h lo=%h, required lat=34 hi=00000000 lo=80000000",
               r_lat, r_hd, r_ld);
    end
  endtask

  task automatic test_mt();
    run_op(3'd1, 32'd5, 32'd7, 32'h0, 32'h0, 0);
    run_op(3'd4, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 0);
    n_assert++;
    if (r_lat !== 1 || r_hw !== 1'b1 || r_lw !== 1'b0 || r_hd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL mthi: got lat=%0d we=%b%b hi=%h, required lat=1 we=10 hi=deadbeef",
               r_lat, r_hw, r_lw, r_hd);
    end
    n_assert++;
    if (r_st0 !== 1'b0 || r_stcnt !== 0 || r_ld !== 32'd35) begin
      n_fail++;
      $display("FAIL mthi_stall_hold: got st0=%b cycles=%0d lo=%h, required 0 0 00000023",
               r_st0, r_stcnt, r_ld);
    end
    run_op(3'd5, 32'h0BAD_F00D, 32'h0, 32'h0, 32'h0, 0);
    n_assert++;
    if (r_lat !== 1 || r_hw !== 1'b0 || r_lw !== 1'b1 || r_ld !== 32'h0BAD_F00D || r_hd !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL mtlo: got lat=%0d we=%b%b lo=%h hi=%h, required lat=1 we=01 lo=0badf00d hi=deadbeef",
               r_lat, r_hw, r_lw, r_ld, r_hd);
    end
  endtask

  task automatic test_madd();
    model(3'd6, 32'd2, 32'd3, 32'd0, 32'd5);
    run_op(3'd6, 32'd2, 32'd3, 32'd0, 32'd5, 0);
    n_assert++;
    if (r_lat !== e_lat || r_st0 !== (e_lat == 2) || r_post_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL madd_timing: got lat=%0d st0=%b busy=%b, required lat=%0d st0=%b busy=0",
               r_lat, r_st0, r_post_busy, e_lat, (e_lat == 2));
    end
`ifdef MDU_MADD_EN
    n_assert++;
    if (r_ld !== 32'd11 || r_hd !== 32'd0) begin
      n_fail++;
      $display("FAIL madd_value: got hi=%h lo=%h, required hi=00000000 lo=0000000b", r_hd, r_ld);
    end
`endif
  endtask

  task automatic test_flush();
    int strobes;
    strobes = 0;
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (hi_we || lo_we) strobes++;
      if (k == 10) flush = 1'b1;
    end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0 || strobes != 0 || hi_we || lo_we) begin
      n_fail++;
      $display("FAIL flush_div: got busy=%b strobes=%0d, required busy=0 strobes=0", busy, strobes);
    end
    @(negedge clk);
    run_op(3'd1, 32'h0001_0000, 32'h0001_0003, 32'h0, 32'h0, 0);
    n_assert++;
    if (r_lat !== 2 || r_hd !== 32'h1 || r_ld !== 32'h0003_0000) begin
      n_fail++;
      $display("FAIL after_flush_multu: got lat=%0d hi=%h lo=%h, required lat=2 hi=00000001 lo=00030000",
               r_lat, r_hd, r_ld);
    end
    // MTHI flushed in its DONE cycle: strobe must vanish that same cycle
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk); flush = 1'b1;
    #1;
    n_assert++;
    if (hi_we !== 1'b0 || lo_we !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_done: got we=%b%b, required 00", hi_we, lo_we);
    end
    @(posedge clk); #1 flush = 1'b0;
    // start together with flush in IDLE is ignored
    @(negedge clk);
    start = 1'b1; op = 3'd0; flush = 1'b1; a = 32'd3; b = 32'd3;
    #1;
    n_assert++;
    if (stall_req !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_stall: got stall=%b, required 0", stall_req);
    end
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    n_assert++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_start_busy: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_rst_mid();
    int strobes;
    strobes = 0;
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_assert++;
    if ({busy, stall_req, hi_we, lo_we, hi_wdata, lo_wdata} !== 68'h0) begin
      n_fail++;
      $display("FAIL rst_mid_div: got busy=%b stall=%b we=%b%b hi=%h lo=%h, required all 0",
               busy, stall_req, hi_we, lo_we, hi_wdata, lo_wdata);
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (hi_we || lo_we || busy) strobes++;
    end
    n_assert++;
    if (strobes != 0) begin
      n_fail++;
      $display("FAIL rst_then_idle: got %0d active cycles, required 0", strobes);
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd5, 32'h7777_0001, 32'h0, 32'h0, 32'h0, 0);
    n_assert++;
    if (r_post_we !== 1'b0 || r_post_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first_end: got we=%b busy=%b after DONE, required 0 0", r_post_we, r_post_busy);
    end
    run_op(3'd0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);
    n_assert++;
    if (r_lat !== 2 || r_hd !== 32'hFFFF_FFFF || r_ld !== 32'hFFFF_FFF0) begin
      n_fail++;
      $display("FAIL b2b_mult: got lat=%0d hi=%h lo=%h, required lat=2 hi=ffffffff lo=fffffff0",
               r_lat, r_hd, r_ld);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] av, bv, hr, lr;
    int          sel;
    for (int i = 0; i < 30; i++) begin
      o  = 3'($urandom_range(0, 7));
      av = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      sel = $urandom_range(0, 7);
      bv = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF :
           (sel == 2) ? 32'($urandom_range(1, 20)) : $urandom;
      hr = $urandom; lr = $urandom;
      model(o, av, bv, hr, lr);
      run_op(o, av, bv, hr, lr, 0);
      n_assert++;
      if (r_lat !== e_lat) begin
        n_fail++;
        $display("FAIL rand_latency op=%0d a=%h b=%h: got %0d, required %0d", o, av, bv, r_lat, e_lat);
      end
      if (e_lat != 0) begin
        n_assert++;
        if ({r_hw, r_lw} !== {e_hw, e_lw}) begin
          n_fail++;
          $display("FAIL rand_we op=%0d: got %b%b, required %b%b", o, r_hw, r_lw, e_hw, e_lw);
        end
      end
      if (e_hw) begin
        n_assert++;
        if (r_hd !== e_hd) begin
          n_fail++;
          $display("FAIL rand_hi op=%0d a=%h b=%h: got %h, required %h", o, av, bv, r_hd, e_hd);
        end
      end
      if (e_lw) begin
        n_assert++;
        if (r_ld !== e_ld) begin
          n_fail++;
          $display("FAIL rand_lo op=%0d a=%h b=%h: got %h, required %h", o, av, bv, r_ld, e_ld);
        end
      end
      n_assert++;
      if (r_st0 !== (e_lat >= 2) || r_stcnt != ((e_lat >= 2) ? e_lat - 1 : 0)) begin
        n_fail++;
        $display("FAIL rand_stall op=%0d: got st0=%b cycles=%0d, required st0=%b cycles=%0d",
                 o, r_st0, r_stcnt, (e_lat >= 2), (e_lat >= 2) ? e_lat - 1 : 0);
      end
      n_assert++;
      if (r_post_we !== 1'b0 || r_post_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_strobe_len op=%0d: got we=%b busy=%b next cycle, required 0 0",
                 o, r_post_we, r_post_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_madd();
    test_flush();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
